// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dvi_pkg
//  Description : Shared types and default 640x480@60 timing for the DVI
//                video timing generator.
//  Revision    : 1.0  initial release
// ============================================================================
package dvi_pkg;

  // Counter width; covers totals up to 2048 pixels/lines.
  localparam int unsigned CNT_W = 11;

  // Default 640x480@60 timing (25.175 MHz pixel clock).
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // One pixel as presented to the red/green/blue encoders.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage : dvi_pkg
`default_nettype wire

// File: rtl/dvi_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dvi_timing_gen
//  Description : Pixel/line counters, show-ahead pixel request, registered
//                DE / HSYNC / VSYNC / RGB for the three TMDS encoders, frame
//                start pulse and sticky source-underflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dvi_timing_gen
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [23:0]       rgb_i,
  input  logic              rgb_vld_i,
  input  logic              ufl_clr_i,
  output logic              pix_req_o,
  output logic [CNT_W-1:0]  x_o,
  output logic [CNT_W-1:0]  y_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic [23:0]       rgb_o,
  output logic              frame_start_o,
  output logic              underflow_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Boundaries are one bit wider so that the sync end (which can reach the
  // total) never wraps in the compare.
  localparam logic [CNT_W:0] H_ACT_E = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SS_E  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SE_E  = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_E = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SS_E  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SE_E  = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic             run_q;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  rgb_t             rgb_q, rgb_d;
  logic             fs_q, fs_d;
  logic             ufl_q, ufl_d;

  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;
  logic             active;
  logic             pix_req;
  logic             hs_win;
  logic             vs_win;

  // Request window and sync windows decoded from the current counter state.
  always_comb begin
    h_ext   = {1'b0, h_q};
    v_ext   = {1'b0, v_q};
    active  = (h_ext < H_ACT_E) && (v_ext < V_ACT_E);
    pix_req = run_q && active;
    hs_win  = run_q && (h_ext >= H_SS_E) && (h_ext < H_SE_E);
    vs_win  = run_q && (v_ext >= V_SS_E) && (v_ext < V_SE_E);
  end

  // Counters advance only while running; dropping en_i snaps them to (0,0)
  // on the same edge that clears run_q, so idle always means (0,0).
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (run_q && en_i) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
      end
    end
  end

  // Next values of the encoder-facing registers, one cycle behind the request.
  always_comb begin
    de_d  = pix_req;
    rgb_d = (pix_req && rgb_vld_i) ? rgb_t'(rgb_i) : '0;
    hs_d  = hs_win ? HS_POL : !HS_POL;
    vs_d  = vs_win ? VS_POL : !VS_POL;
    fs_d  = pix_req && (h_q == '0) && (v_q == '0);
    // A fresh underflow wins over a simultaneous clear.
    if (pix_req && !rgb_vld_i) begin
      ufl_d = 1'b1;
    end else if (ufl_clr_i) begin
      ufl_d = 1'b0;
    end else begin
      ufl_d = ufl_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= !HS_POL;
      vs_q  <= !VS_POL;
      rgb_q <= '0;
      fs_q  <= 1'b0;
      ufl_q <= 1'b0;
    end else begin
      run_q <= en_i;
      h_q   <= h_d;
      v_q   <= v_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
      ufl_q <= ufl_d;
    end
  end

  assign pix_req_o     = pix_req;
  assign x_o           = h_q;
  assign y_o           = v_q;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign rgb_o         = rgb_q;
  assign frame_start_o = fs_q;
  assign underflow_o   = ufl_q;

endmodule : dvi_timing_gen
`default_nettype wire
